// File: rtl/cmp_window_pkg.sv
// Shared types and helpers for the windowed comparator statistics stage.
package cmp_window_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Wide enough to hold the value win itself, so an all-equal window is representable.
  function automatic int cnt_width(input int win);
    return $clog2(win + 1);
  endfunction

  typedef struct packed {
    logic [31:0] min;
    logic [31:0] max;
    logic [31:0] lt;
    logic [31:0] gt;
    logic [31:0] eq;
  } summary_t;

endpackage

// File: rtl/cmp_window_stats_comparator.sv
// Unsigned N-bit magnitude comparator with one-hot Lesser/Greater/Equal outputs.
module N_bit_comparator #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         Lesser,
  output logic         Greater,
  output logic         Equal
);

  assign Lesser  = (a < b);
  assign Greater = (a > b);
  assign Equal   = (a == b);

endmodule

// File: rtl/cmp_window_stats.sv
// Accumulates lt/gt/eq counts plus min/max over windows of WIN samples and
// presents each window summary on a registered valid/ready port.
module cmp_window_stats
  import cmp_window_pkg::*;
#(
  parameter int  N   = 8,
  parameter int  WIN = 16,
  localparam int CW  = cnt_width(WIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  thr,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_min,
  output logic [N-1:0]  out_max,
  output logic [CW-1:0] out_lt_cnt,
  output logic [CW-1:0] out_gt_cnt,
  output logic [CW-1:0] out_eq_cnt
);

  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST_C = CW'(WIN - 1);

  state_t        state_r, state_nx_s;
  logic          in_ready_r, out_valid_r;
  logic [CW-1:0] cnt_r, lt_r, gt_r, eq_r;
  logic [N-1:0]  min_r, max_r, thr_q_r;
  logic [N-1:0]  out_min_r, out_max_r;
  logic [CW-1:0] out_lt_r, out_gt_r, out_eq_r;

  logic          first_s, last_s, acc_s;
  logic          lesser_s, greater_s, equal_s;
  logic [N-1:0]  b_s, min_upd_s, max_upd_s;
  logic [CW-1:0] lt_upd_s, gt_upd_s, eq_upd_s;

  // The first sample of a window is judged against the live threshold it latches.
  assign first_s = (cnt_r == {CW{1'b0}});
  assign last_s  = (cnt_r == LAST_C);
  assign acc_s   = in_valid & in_ready_r;
  assign b_s     = first_s ? thr : thr_q_r;

  N_bit_comparator #(.N(N)) u_cmp (
    .a       (in_data),
    .b       (b_s),
    .Lesser  (lesser_s),
    .Greater (greater_s),
    .Equal   (equal_s)
  );

  assign lt_upd_s  = lt_r + {{(CW-1){1'b0}}, lesser_s};
  assign gt_upd_s  = gt_r + {{(CW-1){1'b0}}, greater_s};
  assign eq_upd_s  = eq_r + {{(CW-1){1'b0}}, equal_s};
  assign min_upd_s = (first_s || (in_data < min_r)) ? in_data : min_r;
  assign max_upd_s = (first_s || (in_data > max_r)) ? in_data : max_r;

  // Next-state logic for the INIT/ACCUM/HOLD sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_INIT: state_nx_s = ST_ACCUM;
      ST_ACCUM: begin
        if (acc_s && last_s) state_nx_s = ST_HOLD;
        else                 state_nx_s = ST_ACCUM;
      end
      ST_HOLD: begin
        if (out_valid_r && out_ready) state_nx_s = ST_ACCUM;
        else                          state_nx_s = ST_HOLD;
      end
      default: state_nx_s = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_INIT;
    else        state_r <= state_nx_s;
  end

  // Working accumulators, threshold latch and registered summary outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      lt_r        <= {CW{1'b0}};
      gt_r        <= {CW{1'b0}};
      eq_r        <= {CW{1'b0}};
      min_r       <= {N{1'b0}};
      max_r       <= {N{1'b0}};
      thr_q_r     <= {N{1'b0}};
      out_min_r   <= {N{1'b0}};
      out_max_r   <= {N{1'b0}};
      out_lt_r    <= {CW{1'b0}};
      out_gt_r    <= {CW{1'b0}};
      out_eq_r    <= {CW{1'b0}};
    end else begin
      in_ready_r <= (state_nx_s == ST_ACCUM);
      if (acc_s) begin
        min_r <= min_upd_s;
        max_r <= max_upd_s;
        if (first_s) thr_q_r <= thr;
        if (last_s) begin
          out_min_r   <= min_upd_s;
          out_max_r   <= max_upd_s;
          out_lt_r    <= lt_upd_s;
          out_gt_r    <= gt_upd_s;
          out_eq_r    <= eq_upd_s;
          out_valid_r <= 1'b1;
          cnt_r       <= {CW{1'b0}};
          lt_r        <= {CW{1'b0}};
          gt_r        <= {CW{1'b0}};
          eq_r        <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + ONE_C;
          lt_r  <= lt_upd_s;
          gt_r  <= gt_upd_s;
          eq_r  <= eq_upd_s;
        end
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_min    = out_min_r;
  assign out_max    = out_max_r;
  assign out_lt_cnt = out_lt_r;
  assign out_gt_cnt = out_gt_r;
  assign out_eq_cnt = out_eq_r;

endmodule

// File: tb/tb_cmp_window_stats.sv
// Self-checking bench for cmp_window_stats: WIN=4 and WIN=16 instances
// checked against a queue-based window model.
module tb_cmp_window_stats;
  import cmp_window_pkg::*;

  logic       clk, rst_n, rst16_n;
  logic [7:0] thr, in_data;
  logic       in_valid, out_ready;

  logic       in_ready, out_valid;
  logic [7:0] out_min, out_max;
  logic [2:0] out_lt_cnt, out_gt_cnt, out_eq_cnt;

  logic       in_ready16, out_valid16;
  logic [7:0] out_min16, out_max16;
  logic [4:0] out_lt16, out_gt16, out_eq16;

  int tests = 0;
  int fails = 0;

  logic [31:0] acc_q[$];
  logic [31:0] win_thr;
  summary_t    exp_q[$];
  summary_t    got4, got16, e;

  assign got4  = {24'd0, out_min, 24'd0, out_max, 29'd0, out_lt_cnt, 29'd0, out_gt_cnt, 29'd0, out_eq_cnt};
  assign got16 = {24'd0, out_min16, 24'd0, out_max16, 27'd0, out_lt16, 27'd0, out_gt16, 27'd0, out_eq16};

  cmp_window_stats #(.N(8), .WIN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .thr(thr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max),
    .out_lt_cnt(out_lt_cnt), .out_gt_cnt(out_gt_cnt), .out_eq_cnt(out_eq_cnt)
  );

  cmp_window_stats #(.N(8), .WIN(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .thr(thr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready16), .out_valid(out_valid16), .out_ready(out_ready),
    .out_min(out_min16), .out_max(out_max16),
    .out_lt_cnt(out_lt16), .out_gt_cnt(out_gt16), .out_eq_cnt(out_eq16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a window summary is just min/max and a three-way tally against one threshold.
  function automatic summary_t model(input logic [31:0] s[$], input logic [31:0] t);
    summary_t r;
    r = '0;
    r.min = s[0];
    r.max = s[0];
    foreach (s[i]) begin
      if (s[i] < t)      r.lt = r.lt + 32'd1;
      else if (s[i] > t) r.gt = r.gt + 32'd1;
      else               r.eq = r.eq + 32'd1;
      if (s[i] < r.min) r.min = s[i];
      if (s[i] > r.max) r.max = s[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just before the edge that accepts d into dut4.
  task automatic record(input logic [7:0] d);
    if (acc_q.size() == 0) win_thr = {24'd0, thr};
    acc_q.push_back({24'd0, d});
    if (acc_q.size() == 4) begin
      exp_q.push_back(model(acc_q, win_thr));
      acc_q.delete();
    end
  endtask

  task automatic send(input logic [7:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready === 1'b1) begin
        record(d);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL send_timeout got=no_accept exp=accept data=%h", d);
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      e = '1;
      $display("FAIL model_queue_empty got=0 exp=>0");
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++;
    if ({in_ready, out_valid} !== 2'b00 || got4 !== '0) begin
      fails++;
      $display("FAIL reset_values got=rdy%b vld%b sum=%h exp=0", in_ready, out_valid, got4);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge got=%b exp=0", in_ready);
    end
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_edge got=rdy%b vld%b exp=rdy1 vld0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    thr = 8'h80;
    send(8'h10);
    send(8'h80);
    send(8'hFF);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_early_valid got=%b exp=0", out_valid);
    end
    send(8'h90);
    pop_exp();
    tests++;
    if (out_valid !== 1'b1 || got4 !== e) begin
      fails++;
      $display("FAIL basic_summary got=vld%b %h exp=vld1 %h", out_valid, got4, e);
    end
    tests++;
    if ({out_min, out_max, out_lt_cnt, out_gt_cnt, out_eq_cnt} !== {8'h10, 8'hFF, 3'd1, 3'd2, 3'd1}) begin
      fails++;
      $display("FAIL basic_fields got=%h %h %0d %0d %0d exp=10 ff 1 2 1", out_min, out_max, out_lt_cnt, out_gt_cnt, out_eq_cnt);
    end
    ack();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_handshake got=vld%b rdy%b exp=vld0 rdy1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'($urandom));
    pop_exp();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || got4 !== e) begin
        fails++;
        $display("FAIL hold_cycle%0d got=rdy%b vld%b %h exp=rdy0 vld1 %h", i, in_ready, out_valid, got4, e);
      end
      tick();
    end
    ack();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release got=vld%b rdy%b exp=vld0 rdy1", out_valid, in_ready);
    end
    record(8'hAA);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
    pop_exp();
    tests++;
    if (out_valid !== 1'b1 || got4 !== e) begin
      fails++;
      $display("FAIL post_hold_window got=vld%b %h exp=vld1 %h", out_valid, got4, e);
    end
    ack();
  endtask

  task automatic test_thr_latch();
    thr = 8'h40;
    send(8'h50);
    thr = 8'hF0;
    for (int i = 0; i < 3; i++) send(8'h50);
    pop_exp();
    tests++;
    if (got4 !== e || out_gt_cnt !== 3'd4) begin
      fails++;
      $display("FAIL thr_latch_first got=%h gt=%0d exp=%h gt=4", got4, out_gt_cnt, e);
    end
    ack();
    send(8'hF0);
    thr = 8'h10;
    send(8'hEF);
    send(8'hF1);
    send(8'h50);
    pop_exp();
    tests++;
    if (got4 !== e || {out_lt_cnt, out_gt_cnt, out_eq_cnt} !== {3'd2, 3'd1, 3'd1}) begin
      fails++;
      $display("FAIL thr_latch_next got=%h exp=%h", got4, e);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    int nsum, nacc, low_run;
    nsum = 0; nacc = 0; low_run = 0;
    thr = 8'h80;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 60 && nsum < 3; c++) begin
      in_data = 8'($urandom);
      if (in_ready === 1'b1) begin
        if (low_run > 0) begin
          tests++;
          if (low_run != 1) begin
            fails++;
            $display("FAIL b2b_gap got=%0d exp=1", low_run);
          end
        end
        low_run = 0;
        record(in_data);
        nacc++;
      end else begin
        low_run++;
      end
      if (out_valid === 1'b1) begin
        pop_exp();
        tests++;
        if (got4 !== e) begin
          fails++;
          $display("FAIL b2b_summary%0d got=%h exp=%h", nsum, got4, e);
        end
        nsum++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (nsum != 3 || nacc != 12 || acc_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_totals got=sum%0d acc%0d exp=sum3 acc12", nsum, nacc);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h00);
    send(8'hFF);
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || got4 !== '0) begin
      fails++;
      $display("FAIL mid_reset got=vld%b rdy%b %h exp=0", out_valid, in_ready, got4);
    end
    acc_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_release got=rdy%b vld%b exp=rdy1 vld0", in_ready, out_valid);
    end
    for (int i = 0; i < 4; i++) send(8'($urandom_range(32, 224)));
    pop_exp();
    tests++;
    if (out_valid !== 1'b1 || got4 !== e) begin
      fails++;
      $display("FAIL mid_reset_window got=vld%b %h exp=vld1 %h", out_valid, got4, e);
    end
    ack();
  endtask

  task automatic test_random();
    int nsum;
    nsum = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) thr = 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? thr : 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready === 1'b1) record(in_data);
      if (out_ready && out_valid === 1'b1) begin
        pop_exp();
        tests++;
        if (got4 !== e) begin
          fails++;
          $display("FAIL random_summary%0d got=%h exp=%h", nsum, got4, e);
        end
        nsum++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid === 1'b1) begin
        pop_exp();
        tests++;
        if (got4 !== e) begin
          fails++;
          $display("FAIL random_drain got=%h exp=%h", got4, e);
        end
        nsum++;
      end
      tick();
    end
    out_ready = 1'b0;
    tests++;
    if (exp_q.size() != 0 || nsum < 20) begin
      fails++;
      $display("FAIL random_count got=left%0d seen%0d exp=left0 seen>=20", exp_q.size(), nsum);
    end
    acc_q.delete();
  endtask

  task automatic test_saturation();
    logic [31:0] sq[$];
    summary_t    es;
    int          n;
    n = 0;
    for (int i = 0; i < 16; i++) sq.push_back(32'h33);
    es = model(sq, 32'h33);
    thr = 8'h33;
    in_data = 8'h33;
    out_ready = 1'b0;
    rst16_n = 1'b1;
    tick();
    in_valid = 1'b1;
    for (int c = 0; c < 40 && n < 16; c++) begin
      if (in_ready16 === 1'b1) n++;
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (n != 16 || out_valid16 !== 1'b1 || got16 !== es || out_eq16 !== 5'd16) begin
      fails++;
      $display("FAIL saturation got=n%0d vld%b %h exp=n16 vld1 %h", n, out_valid16, got16, es);
    end
    ack();
    tests++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      fails++;
      $display("FAIL saturation_ack got=vld%b rdy%b exp=vld0 rdy1", out_valid16, in_ready16);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst16_n = 1'b0;
    thr = 8'h00; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_thr_latch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmp_window_stats.md
# cmp_window_stats

Windowed statistics stage sitting directly downstream of the N-bit magnitude comparator. It consumes a valid/ready sample stream and compares each sample against a threshold using the comparator's Lesser/Greater/Equal outputs. Over each window of WIN accepted samples it counts below/above/equal results and tracks the window minimum and maximum. It then presents one registered summary on a valid/ready output port.

## Interface
- N, 8, sample and threshold width (≥1)
- WIN, 16, samples per window (≥2); localparam CW = $clog2(WIN+1) is the counter width
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- thr  input  N  threshold, unsigned; latched once per window
- in_valid  input  1  sample present
- in_data  input  N  sample, unsigned
- in_ready  output  1  stage accepts a sample this cycle
- out_valid  output  1  window summary present
- out_ready  input  1  consumer takes summary
- out_min  output  N  smallest sample in window
- out_max  output  N  largest sample in window
- out_lt_cnt  output  CW  samples with in_data < threshold
- out_gt_cnt  output  CW  samples with in_data > threshold
- out_eq_cnt  output  CW  samples with in_data == threshold

## Operation
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- FSM states: INIT, ACCUM, HOLD. Reset enters INIT.
- INIT: in_ready=0. Go to ACCUM unconditionally on the next edge.
- ACCUM: in_ready=1. A sample is accepted on any edge with in_valid & in_ready.
- Per accepted sample:
  - Increment exactly one of lt/gt/eq, based on the comparator result.
  - Increment the sample counter.
  - Update min/max with strict compares; ties keep the stored value.
- First sample of a window (sample counter == 0):
  - Compare it against the live thr.
  - Latch thr into thr_q. The rest of the window compares against thr_q.
  - Initialise min and max to that sample, ignoring prior values.
- When the WIN-th sample is accepted:
  - Load the final counts, min and max, including this sample, into the output registers.
  - Set out_valid. Clear the working counters. Go to HOLD.
- HOLD: in_ready=0 and in_valid is ignored. Output registers are frozen.
  - On out_valid & out_ready: clear out_valid and go to ACCUM.
- in_valid gaps in ACCUM simply stall accumulation, with no timeout.
- Counts always sum to WIN in a summary. CW holds WIN exactly, e.g. eq=WIN is representable.
- A thr change mid-window has no effect until the next window's first sample.
- Reset mid-window or mid-HOLD discards all partial state. No summary is emitted.

## Timing
- Reset values: in_ready=0, out_valid=0, out_min=0, out_max=0, all counts 0, thr_q=0, state INIT.
- in_ready and out_valid are registered; neither is a combinational function of in_valid or out_ready.
- in_ready rises one cycle after rst_n deasserts, i.e. after the first clk edge.
- Latency: WIN-th sample accepted at edge k, so out_valid=1 and the summary is valid from edge k onward.
- Earliest HOLD exit: handshake at edge k+1, ACCUM from edge k+1, next sample accepted at edge k+2.
- With out_ready tied high, in_ready is low for exactly one cycle between windows.
- Throughput: at most WIN samples per WIN+1 cycles.
- Output data is stable for every cycle that out_valid=1 and out_ready=0.

## Structure
- Package cmp_window_pkg holds:
  - the state enum (INIT, ACCUM, HOLD);
  - a count-width helper function;
  - a summary struct {min, max, lt, gt, eq}.
- One sub-module: N_bit_comparator with parameter N.
  - a = in_data; b = threshold mux (live thr when the sample counter is 0, else thr_q).
  - Its one-hot Lesser/Greater/Equal outputs drive the count increments directly.
- The min/max compares are inline in this block; they are not extra comparator instances.

## Test plan
- Basic window: N=8, WIN=4, thr=0x80, samples 0x10,0x80,0xFF,0x90 -> min=0x10, max=0xFF, lt=1, eq=1, gt=2. out_valid rises at the edge that accepts 0x90.
- Backpressure: hold out_ready=0 for 5 cycles after the summary while driving in_valid=1 -> in_ready=0 throughout, outputs unchanged, no sample consumed. The first post-handshake sample starts a fresh window.
- Threshold latch: thr=0x40 at the first sample, then 0xF0 mid-window. Samples 0x50 ×4 -> gt=4. The next window compares against 0xF0.
- Saturation, WIN=16: 16 samples all equal to thr=0x33 -> eq=16 (CW=5), lt=gt=0, min=max=0x33.
- Back-to-back with out_ready=1 and in_valid=1 always: 3 consecutive windows -> in_ready low exactly one cycle between windows, 3 summaries, no samples dropped or double-counted.
- Reset mid-window: 2 of 4 samples accepted, then rst_n pulsed low -> out_valid=0, in_ready=0 during reset, 1 a cycle after release. The next 4 samples produce a summary with no stale data.
